regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised successor to the core's register file: 2^ADDR_W architectural registers, the top one being the program counter. Two registered read ports, one write port, PC-relative read of the top register and a redirect output for PC writes. A per-register busy scoreboard flags operands that still await a multi-cycle writeback. It sits between decode (reads, busy-set) and writeback (write port), and feeds the PC unit.

## Interface
Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 4, register address width; NREGS = 2^ADDR_W, top address PCA = NREGS-1
- PC_OFFSET, 8, constant added to R15 when PCA is read

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- A1  in  ADDR_W  read address, port 1
- A2  in  ADDR_W  read address, port 2
- A3  in  ADDR_W  write address
- WD3  in  DATA_W  write data
- WE3  in  1  write enable
- R15  in  DATA_W  current PC from PC unit
- BSE  in  1  busy-set enable (decode issued a multi-cycle producer)
- BSA  in  ADDR_W  busy-set address
- RD1  out  DATA_W  registered read data, port 1
- RD2  out  DATA_W  registered read data, port 2
- BUSY1  out  1  registered busy flag for A1 operand
- BUSY2  out  1  registered busy flag for A2 operand
- PCWE  out  1  one-cycle pulse: PC write requested
- PCWD  out  DATA_W  PC write data, valid when PCWE=1

## Operation
- Storage: NREGS-1 registers (0..PCA-1); PCA has no storage.
- Write: WE3=1 and A3<PCA → regs[A3] <= WD3 at edge. WE3=1 and A3==PCA → no storage write; PCWE<=1, PCWD<=WD3 next edge. Otherwise PCWE<=0, PCWD holds.
- Read port n (n=1,2), sampled each edge:
  - An==PCA → RDn <= R15 + PC_OFFSET, truncated to DATA_W (wraps modulo 2^DATA_W).
  - else bypass case (see Configuration) or RDn <= regs[An] pre-edge value.
- Scoreboard: busy[NREGS-1:0], busy[PCA] always 0.
  - WE3=1, A3<PCA → busy[A3] <= 0.
  - BSE=1, BSA<PCA → busy[BSA] <= 1; BSE with BSA==PCA ignored.
  - Same address set and clear in one cycle → set wins (new producer outstanding).
  - BUSYn <= busy[An] pre-edge, except: cleared same cycle by write → 0 when BYPASS_EN defined; set same cycle by BSE → 1 always.
- Reset (async, rst=1): all regs 0, busy all 0, RD1=RD2=0, BUSY1=BUSY2=0, PCWE=0, PCWD=0; held while rst=1. Writes/sets in the reset cycle are lost.

## Timing
- Read latency: 1 cycle (address at edge k → RDn/BUSYn valid after edge k).
- Write visible to a non-bypassed read starting the cycle after WE3 edge.
- PCWE asserted exactly one cycle after the WE3 edge; never two consecutive cycles unless WE3 to PCA on consecutive cycles.
- R15 sampled at same edge as A1/A2; no internal PC state.
- No back-pressure; all inputs accepted every cycle.

## Configuration
- REGFILE_BYPASS_EN defined: write-first. WE3=1, A3==An, A3<PCA → RDn <= WD3 and BUSYn <= 0 (unless same-cycle BSE to that address).
- Undefined: read-first. RDn returns old regs[An]; BUSYn reflects pre-edge busy bit.
- PCA reads never bypass in either mode.

## Test plan
- Reset: assert rst mid-run after writing regs[3]=0xDEADBEEF → RD1=RD2=0, PCWE=0 immediately; after release, read A1=3 → RD1=0.
- Write/read: WE3=1,A3=5,WD3=0x1234 at edge k; A1=5 at edge k+1 → RD1=0x1234 after k+1; A2=0 → RD2=0.
- PC read: R15=0x100, A1=15 → RD1=0x108; R15=0xFFFFFFFC → RD1=0x00000004 (wrap).
- PC write: WE3=1,A3=15,WD3=0x200 → PCWE=1,PCWD=0x200 for one cycle; subsequent A1=15 with R15=0x40 → RD1=0x48 (no storage).
- Bypass: regs[7]=0xAA; same cycle WE3=1,A3=7,WD3=0xBB,A1=7 → RD1=0xBB with REGFILE_BYPASS_EN, 0xAA without.
- Scoreboard: BSE=1,BSA=2 → next cycle A1=2 gives BUSY1=1; WE3 to reg 2 → BUSY1=0 after; simultaneous BSE and WE3 on reg 2 → busy stays 1; BSE,BSA=15 → BUSY1=0 for A1=15.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with a PC-relative top register, PC redirect on writes to it, and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads (same-cycle write data and busy clear forwarded to the read ports).
module regfile_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int PC_OFFSET = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  input  logic [DATA_W-1:0] R15,
  input  logic              BSE,
  input  logic [ADDR_W-1:0] BSA,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic              PCWE,
  output logic [DATA_W-1:0] PCWD
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PCA = ADDR_W'(NREGS - 1);

  logic [DATA_W-1:0] regs_q [NREGS-1];
  logic [DATA_W-1:0] regs_d [NREGS-1];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] rd_q [2];
  logic [DATA_W-1:0] rd_d [2];
  logic [1:0]        busy_rd_q, busy_rd_d;
  logic              pcwe_q, pcwe_d;
  logic [DATA_W-1:0] pcwd_q, pcwd_d;

  logic              wr_reg;
  logic              set_reg;
  logic [ADDR_W-1:0] ra;

  always_comb begin
    wr_reg  = WE3 && (A3 != PCA);
    set_reg = BSE && (BSA != PCA);

    regs_d = regs_q;
    if (wr_reg) regs_d[A3] = WD3;

    // Set is applied after clear so a newly issued producer wins over a retiring one.
    busy_d = busy_q;
    if (wr_reg)  busy_d[A3]  = 1'b0;
    if (set_reg) busy_d[BSA] = 1'b1;
    busy_d[PCA] = 1'b0;

    pcwe_d = WE3 && (A3 == PCA);
    pcwd_d = pcwe_d ? WD3 : pcwd_q;

    ra = '0;
    for (int n = 0; n < 2; n++) begin
      ra = (n == 0) ? A1 : A2;
      rd_d[n]      = '0;
      busy_rd_d[n] = 1'b0;
      if (ra == PCA) begin
        rd_d[n]      = R15 + DATA_W'(PC_OFFSET);
        busy_rd_d[n] = 1'b0;
      end else begin
        rd_d[n]      = regs_q[ra];
        busy_rd_d[n] = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr_reg && (A3 == ra)) begin
          rd_d[n]      = WD3;
          busy_rd_d[n] = 1'b0;
        end
`endif
        if (set_reg && (BSA == ra)) busy_rd_d[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS - 1; i++) regs_q[i] <= '0;
      busy_q    <= '0;
      rd_q[0]   <= '0;
      rd_q[1]   <= '0;
      busy_rd_q <= '0;
      pcwe_q    <= 1'b0;
      pcwd_q    <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      rd_q[0]   <= rd_d[0];
      rd_q[1]   <= rd_d[1];
      busy_rd_q <= busy_rd_d;
      pcwe_q    <= pcwe_d;
      pcwd_q    <= pcwd_d;
    end
  end

  assign RD1   = rd_q[0];
  assign RD2   = rd_q[1];
  assign BUSY1 = busy_rd_q[0];
  assign BUSY2 = busy_rd_q[1];
  assign PCWE  = pcwe_q;
  assign PCWD  = pcwd_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, read/write, PC read/write, bypass mode and scoreboard.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  A1, A2, A3, BSA;
  logic [31:0] WD3, R15;
  logic        WE3, BSE;
  logic [31:0] RD1, RD2, PCWD;
  logic        BUSY1, BUSY2, PCWE;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(4), .PC_OFFSET(8)) dut (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
    .R15(R15), .BSE(BSE), .BSA(BSA), .RD1(RD1), .RD2(RD2), .BUSY1(BUSY1),
    .BUSY2(BUSY2), .PCWE(PCWE), .PCWD(PCWD)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE3 = 1'b0; BSE = 1'b0; A3 = 4'd0; BSA = 4'd0; WD3 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; A1 = 4'd0; A2 = 4'd0; R15 = '0; idle();
    tick();
    checks++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0 || BUSY1 !== 1'b0 || BUSY2 !== 1'b0 || PCWE !== 1'b0 || PCWD !== 32'h0) begin
      failures++;
      $display("FAIL reset_init: RD1=%h RD2=%h B1=%b B2=%b PCWE=%b PCWD=%h want all zero", RD1, RD2, BUSY1, BUSY2, PCWE, PCWD);
    end
    rst = 1'b0;
    WE3 = 1'b1; A3 = 4'd3; WD3 = 32'hDEADBEEF;
    tick();
    // Read back reg 3 while redirecting the PC, so reset has non-zero outputs to clear.
    WE3 = 1'b1; A3 = 4'd15; WD3 = 32'h0000_0300; A1 = 4'd3; A2 = 4'd3;
    tick();
    idle();
    checks++;
    if (RD1 !== 32'hDEADBEEF || PCWE !== 1'b1) begin
      failures++;
      $display("FAIL reset_prefill: RD1=%h PCWE=%b want deadbeef 1", RD1, PCWE);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0 || PCWE !== 1'b0 || PCWD !== 32'h0) begin
      failures++;
      $display("FAIL reset_async: RD1=%h RD2=%h PCWE=%b PCWD=%h want 0", RD1, RD2, PCWE, PCWD);
    end
    tick();
    rst = 1'b0;
    A1 = 4'd3;
    tick();
    checks++;
    if (RD1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_reg3: RD1=%h want 00000000", RD1);
    end
  endtask

  task automatic test_write_read();
    WE3 = 1'b1; A3 = 4'd5; WD3 = 32'h0000_1234;
    tick();
    WE3 = 1'b1; A3 = 4'd9; WD3 = 32'h5555_AAAA; A1 = 4'd5; A2 = 4'd0;
    tick();
    checks++;
    if (RD1 !== 32'h0000_1234 || RD2 !== 32'h0) begin
      failures++;
      $display("FAIL write_read_5: RD1=%h RD2=%h want 00001234 00000000", RD1, RD2);
    end
    idle(); A1 = 4'd9; A2 = 4'd5;
    tick();
    checks++;
    if (RD1 !== 32'h5555_AAAA || RD2 !== 32'h0000_1234) begin
      failures++;
      $display("FAIL write_read_9: RD1=%h RD2=%h want 5555aaaa 00001234", RD1, RD2);
    end
  endtask

  task automatic test_pc_read();
    A1 = 4'd15; R15 = 32'h0000_0100; A2 = 4'd5;
    tick();
    checks++;
    if (RD1 !== 32'h0000_0108 || RD2 !== 32'h0000_1234 || BUSY1 !== 1'b0) begin
      failures++;
      $display("FAIL pc_read: RD1=%h RD2=%h B1=%b want 00000108 00001234 0", RD1, RD2, BUSY1);
    end
    A2 = 4'd15; R15 = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (RD1 !== 32'h0000_0004 || RD2 !== 32'h0000_0004) begin
      failures++;
      $display("FAIL pc_read_wrap: RD1=%h RD2=%h want 00000004", RD1, RD2);
    end
  endtask

  task automatic test_pc_write();
    WE3 = 1'b1; A3 = 4'd15; WD3 = 32'h0000_0200; A1 = 4'd0; A2 = 4'd5;
    tick();
    idle();
    checks++;
    if (PCWE !== 1'b1 || PCWD !== 32'h0000_0200) begin
      failures++;
      $display("FAIL pc_write_pulse: PCWE=%b PCWD=%h want 1 00000200", PCWE, PCWD);
    end
    A1 = 4'd15; R15 = 32'h0000_0040;
    tick();
    checks++;
    if (PCWE !== 1'b0 || PCWD !== 32'h0000_0200) begin
      failures++;
      $display("FAIL pc_write_end: PCWE=%b PCWD=%h want 0 00000200", PCWE, PCWD);
    end
    checks++;
    if (RD1 !== 32'h0000_0048 || RD2 !== 32'h0000_1234) begin
      failures++;
      $display("FAIL pc_write_nostore: RD1=%h RD2=%h want 00000048 00001234", RD1, RD2);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rd;
`ifdef REGFILE_BYPASS_EN
    exp_rd = 32'h0000_00BB;
`else
    exp_rd = 32'h0000_00AA;
`endif
    WE3 = 1'b1; A3 = 4'd7; WD3 = 32'h0000_00AA; A1 = 4'd0;
    tick();
    WE3 = 1'b1; A3 = 4'd7; WD3 = 32'h0000_00BB; A1 = 4'd7;
    tick();
    idle();
    checks++;
    if (RD1 !== exp_rd) begin
      failures++;
      $display("FAIL bypass_same_cycle: RD1=%h want %h", RD1, exp_rd);
    end
    tick();
    checks++;
    if (RD1 !== 32'h0000_00BB) begin
      failures++;
      $display("FAIL bypass_after: RD1=%h want 000000bb", RD1);
    end
  endtask

  task automatic test_scoreboard();
    logic exp_b;
`ifdef REGFILE_BYPASS_EN
    exp_b = 1'b0;
`else
    exp_b = 1'b1;
`endif
    BSE = 1'b1; BSA = 4'd2; A1 = 4'd2; A2 = 4'd3;
    tick();
    BSE = 1'b0;
    checks++;
    if (BUSY1 !== 1'b1 || BUSY2 !== 1'b0) begin
      failures++;
      $display("FAIL busy_set_same: B1=%b B2=%b want 1 0", BUSY1, BUSY2);
    end
    A2 = 4'd2;
    tick();
    checks++;
    if (BUSY1 !== 1'b1 || BUSY2 !== 1'b1) begin
      failures++;
      $display("FAIL busy_held: B1=%b B2=%b want 1 1", BUSY1, BUSY2);
    end
    WE3 = 1'b1; A3 = 4'd2; WD3 = 32'h0000_0022;
    tick();
    idle();
    checks++;
    if (BUSY1 !== exp_b) begin
      failures++;
      $display("FAIL busy_clear_same: B1=%b want %b", BUSY1, exp_b);
    end
    tick();
    checks++;
    if (BUSY1 !== 1'b0 || RD1 !== 32'h0000_0022) begin
      failures++;
      $display("FAIL busy_cleared: B1=%b RD1=%h want 0 00000022", BUSY1, RD1);
    end
    BSE = 1'b1; BSA = 4'd2; WE3 = 1'b1; A3 = 4'd2; WD3 = 32'h0000_0033;
    tick();
    idle();
    checks++;
    if (BUSY1 !== 1'b1) begin
      failures++;
      $display("FAIL busy_set_wins_same: B1=%b want 1", BUSY1);
    end
    tick();
    checks++;
    if (BUSY1 !== 1'b1 || BUSY2 !== 1'b1) begin
      failures++;
      $display("FAIL busy_set_wins: B1=%b B2=%b want 1 1", BUSY1, BUSY2);
    end
    BSE = 1'b1; BSA = 4'd15; A1 = 4'd15; A2 = 4'd4;
    tick();
    idle();
    checks++;
    if (BUSY1 !== 1'b0 || BUSY2 !== 1'b0) begin
      failures++;
      $display("FAIL busy_pca_same: B1=%b B2=%b want 0 0", BUSY1, BUSY2);
    end
    tick();
    checks++;
    if (BUSY1 !== 1'b0) begin
      failures++;
      $display("FAIL busy_pca: B1=%b want 0", BUSY1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_pc_read();
    test_pc_write();
    test_bypass();
    test_scoreboard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
